// File: rtl/count_capture_pkg.sv
// +----------------------------------------------------------------------+
// | count_capture_pkg                                                    |
// | Shared defaults, derived widths and sample type for count capture.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package count_capture_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;
    localparam int PTR_W     = $clog2(DEF_DEPTH);
    localparam int LVL_W     = PTR_W + 1;

    typedef logic [DEF_WIDTH-1:0] count_t;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// +----------------------------------------------------------------------+
// | sync_fifo                                                            |
// | First-word-fall-through synchronous FIFO with level tracking.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module sync_fifo
    import count_capture_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_push_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_valid,
    output logic                       o_full,
    output logic [$clog2(DEPTH):0]     o_level
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_LVL_W = c_PTR_W + 1;
    localparam logic [c_LVL_W-1:0] c_FULL_LVL = c_LVL_W'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_LVL_W-1:0] r_level;

    logic w_empty;
    logic w_full;
    logic w_do_pop;
    logic w_do_push;

    assign w_empty   = (r_level == '0);
    assign w_full    = (r_level == c_FULL_LVL);
    assign w_do_pop  = i_pop & ~w_empty;
    // When full, a simultaneous pop frees the slot the write pointer targets.
    assign w_do_push = i_push & (~w_full | w_do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + c_LVL_W'(1);
                2'b01:   r_level <= r_level - c_LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_valid = ~w_empty;
    assign o_full  = w_full;
    assign o_level = r_level;

endmodule

`default_nettype wire

// File: rtl/count_capture_fifo.sv
// +----------------------------------------------------------------------+
// | count_capture_fifo                                                   |
// | Captures the free-running count on each rising event into a FIFO.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module count_capture_fifo
    import count_capture_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       i_count,
    input  logic                   i_event,
    output logic [WIDTH-1:0]       o_cap_data,
    output logic                   o_cap_valid,
    input  logic                   i_cap_ready,
    output logic [$clog2(DEPTH):0] o_level,
    output logic                   o_overflow,
    input  logic                   i_clear_ovf
);

    logic r_event_d;
    logic r_overflow;

    logic w_capture;
    logic w_pop;
    logic w_full;
    logic w_drop;

    assign w_capture = i_event & ~r_event_d;
    assign w_pop     = o_cap_valid & i_cap_ready;
    assign w_drop    = w_capture & w_full & ~w_pop;

    // Event history resets high so a level held through reset is not a capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_event_d  <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            r_event_d <= i_event;
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (i_clear_ovf) begin
                r_overflow <= 1'b0;
            end
        end
    end

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_capture),
        .i_push_data (i_count),
        .i_pop       (i_cap_ready),
        .o_data      (o_cap_data),
        .o_valid     (o_cap_valid),
        .o_full      (w_full),
        .o_level     (o_level)
    );

    assign o_overflow = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_count_capture_fifo.sv
// +----------------------------------------------------------------------+
// | tb_count_capture_fifo                                                |
// | Scenario tasks plus randomized traffic against a queue-based model.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_count_capture_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [WIDTH-1:0] i_count = '0;
    logic             i_event = 1'b0;
    logic [WIDTH-1:0] o_cap_data;
    logic             o_cap_valid;
    logic             i_cap_ready = 1'b0;
    logic [2:0]       o_level;
    logic             o_overflow;
    logic             i_clear_ovf = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    logic [WIDTH-1:0] m_q [$];
    logic             m_ovf = 1'b0;
    logic             m_prev = 1'b1;

    count_capture_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .i_count     (i_count),
        .i_event     (i_event),
        .o_cap_data  (o_cap_data),
        .o_cap_valid (o_cap_valid),
        .i_cap_ready (i_cap_ready),
        .o_level     (o_level),
        .o_overflow  (o_overflow),
        .i_clear_ovf (i_clear_ovf)
    );

    always #5 clk = ~clk;

    // Apply one cycle of inputs, advance the reference model, then settle past the edge.
    task automatic step(input logic rst, input logic ev, input logic [WIDTH-1:0] cnt,
                        input logic rdy, input logic clr);
        logic cap, pop, drop;
        reset = rst; i_event = ev; i_count = cnt; i_cap_ready = rdy; i_clear_ovf = clr;
        if (rst) begin
            m_q.delete();
            m_ovf  = 1'b0;
            m_prev = 1'b1;
        end else begin
            cap  = ev && !m_prev;
            pop  = (m_q.size() != 0) && rdy;
            drop = cap && (m_q.size() == DEPTH) && !pop;
            if (pop) void'(m_q.pop_front());
            if (cap && !drop) m_q.push_back(cnt);
            if (drop) m_ovf = 1'b1;
            else if (clr) m_ovf = 1'b0;
            m_prev = ev;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, '0, 1'b0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic fill4(input logic [WIDTH-1:0] a, b, c, d);
        logic [WIDTH-1:0] v [4];
        v = '{a, b, c, d};
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, v[i], 1'b0, 1'b0);
            step(1'b0, 1'b0, 8'hFF, 1'b0, 1'b0);
        end
    endtask

    task automatic test_reset();
        step(1'b1, 1'b1, 8'h55, 1'b1, 1'b1);
        step(1'b1, 1'b1, 8'h56, 1'b1, 1'b0);
        n_cmp++;
        if (o_level !== 3'd0 || o_cap_valid !== 1'b0 || o_overflow !== 1'b0) begin
            n_err++;
            $display("FAIL reset: level=%0d valid=%b ovf=%b, required 0/0/0", o_level, o_cap_valid, o_overflow);
        end
    endtask

    task automatic test_first_capture();
        do_reset();
        step(1'b0, 1'b1, 8'h2A, 1'b0, 1'b0);
        n_cmp++;
        if (o_cap_valid !== 1'b1 || o_cap_data !== 8'h2A || o_level !== 3'd1) begin
            n_err++;
            $display("FAIL first_capture: valid=%b data=%h level=%0d, required 1/2a/1", o_cap_valid, o_cap_data, o_level);
        end
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        n_cmp++;
        if (o_cap_data !== 8'h2A || o_level !== 3'd1) begin
            n_err++;
            $display("FAIL hold_no_ready: data=%h level=%0d, required 2a/1", o_cap_data, o_level);
        end
    endtask

    task automatic test_fill_drain();
        logic [WIDTH-1:0] exp [4];
        exp = '{8'd3, 8'd7, 8'd11, 8'd15};
        do_reset();
        fill4(8'd3, 8'd7, 8'd11, 8'd15);
        n_cmp++;
        if (o_level !== 3'd4 || o_overflow !== 1'b0) begin
            n_err++;
            $display("FAIL fill_level: level=%0d ovf=%b, required 4/0", o_level, o_overflow);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (o_cap_valid !== 1'b1 || o_cap_data !== exp[i]) begin
                n_err++;
                $display("FAIL drain[%0d]: valid=%b data=%0d, required 1/%0d", i, o_cap_valid, o_cap_data, exp[i]);
            end
            step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        end
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        n_cmp++;
        if (o_cap_valid !== 1'b0 || o_level !== 3'd0) begin
            n_err++;
            $display("FAIL drained_empty: valid=%b level=%0d, required 0/0", o_cap_valid, o_level);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        fill4(8'd1, 8'd2, 8'd3, 8'd4);
        step(1'b0, 1'b1, 8'd20, 1'b0, 1'b0);
        n_cmp++;
        if (o_overflow !== 1'b1 || o_level !== 3'd4) begin
            n_err++;
            $display("FAIL overflow_set: ovf=%b level=%0d, required 1/4", o_overflow, o_level);
        end
        step(1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (o_cap_data !== 8'(i + 1)) begin
                n_err++;
                $display("FAIL overflow_drain[%0d]: data=%0d, required %0d", i, o_cap_data, i + 1);
            end
            step(1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
        end
        n_cmp++;
        if (o_cap_valid !== 1'b0 || o_overflow !== 1'b1) begin
            n_err++;
            $display("FAIL overflow_sticky: valid=%b ovf=%b, required 0/1", o_cap_valid, o_overflow);
        end
    endtask

    task automatic test_full_push_pop();
        logic [WIDTH-1:0] exp [4];
        exp = '{8'd6, 8'd7, 8'd8, 8'd30};
        do_reset();
        fill4(8'd5, 8'd6, 8'd7, 8'd8);
        step(1'b0, 1'b1, 8'd30, 1'b1, 1'b0);
        n_cmp++;
        if (o_overflow !== 1'b0 || o_level !== 3'd4) begin
            n_err++;
            $display("FAIL full_push_pop: ovf=%b level=%0d, required 0/4", o_overflow, o_level);
        end
        step(1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (o_cap_data !== exp[i]) begin
                n_err++;
                $display("FAIL full_push_pop_drain[%0d]: data=%0d, required %0d", i, o_cap_data, exp[i]);
            end
            step(1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
        end
    endtask

    task automatic test_clear_ovf();
        do_reset();
        fill4(8'd9, 8'd10, 8'd11, 8'd12);
        step(1'b0, 1'b1, 8'd40, 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'd41, 1'b0, 1'b1);
        n_cmp++;
        if (o_overflow !== 1'b1) begin
            n_err++;
            $display("FAIL clear_vs_drop: ovf=%b, required 1", o_overflow);
        end
        step(1'b0, 1'b0, 8'd0, 1'b0, 1'b1);
        n_cmp++;
        if (o_overflow !== 1'b0 || o_level !== 3'd4) begin
            n_err++;
            $display("FAIL clear_alone: ovf=%b level=%0d, required 0/4", o_overflow, o_level);
        end
    endtask

    task automatic test_event_through_reset();
        do_reset();
        step(1'b0, 1'b1, 8'd1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'd2, 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'd3, 1'b0, 1'b0);
        n_cmp++;
        if (o_level !== 3'd2) begin
            n_err++;
            $display("FAIL pre_reset_level: level=%0d, required 2", o_level);
        end
        step(1'b1, 1'b1, 8'd4, 1'b1, 1'b0);
        step(1'b1, 1'b1, 8'd5, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 8'(6 + i), 1'b0, 1'b0);
            n_cmp++;
            if (o_level !== 3'd0 || o_cap_valid !== 1'b0) begin
                n_err++;
                $display("FAIL event_held[%0d]: level=%0d valid=%b, required 0/0", i, o_level, o_cap_valid);
            end
        end
        step(1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'd77, 1'b0, 1'b0);
        n_cmp++;
        if (o_level !== 3'd1 || o_cap_data !== 8'd77) begin
            n_err++;
            $display("FAIL event_rearm: level=%0d data=%0d, required 1/77", o_level, o_cap_data);
        end
    endtask

    task automatic test_random();
        logic rst, ev, rdy, clr;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            ev  = $urandom_range(0, 1) == 1;
            rdy = ($urandom_range(0, 99) < 35);
            clr = ($urandom_range(0, 9) == 0);
            step(rst, ev, 8'($urandom), rdy, clr);
            n_cmp++;
            if (o_level !== 3'(m_q.size()) || o_cap_valid !== (m_q.size() != 0) || o_overflow !== m_ovf
                || (m_q.size() != 0 && o_cap_data !== m_q[0])) begin
                n_err++;
                $display("FAIL random[%0d]: level=%0d valid=%b ovf=%b data=%h, required level=%0d ovf=%b data=%h",
                         i, o_level, o_cap_valid, o_overflow, o_cap_data, m_q.size(), m_ovf,
                         (m_q.size() != 0) ? m_q[0] : 8'h00);
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_capture();
        test_fill_drain();
        test_overflow();
        test_full_push_pop();
        test_clear_ovf();
        test_event_through_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/count_capture_fifo.md
COUNT_CAPTURE_FIFO -- requirements
Module: count_capture_fifo

Interface
REQ-001 Parameter WIDTH, default 8: width of captured count samples.
REQ-002 Parameter DEPTH, default 4: number of buffered samples, power of two, at least 2.
REQ-003 clk  input  1: single clock; all state updates on its rising edge.
REQ-004 reset  input  1: synchronous, active-high reset.
REQ-005 count  input  WIDTH: free-running count from the upstream counter stage.
REQ-006 event  input  1: capture trigger, synchronous to clk, level signal.
REQ-007 cap_data  output  WIDTH: oldest buffered sample.
REQ-008 cap_valid  output  1: cap_data holds a buffered sample.
REQ-009 cap_ready  input  1: consumer accepts cap_data this cycle.
REQ-010 level  output  clog2(DEPTH)+1: number of buffered samples.
REQ-011 overflow  output  1: sticky flag, set when a sample was dropped.
REQ-012 clear_ovf  input  1: clears overflow.

Function
REQ-013 The block shall detect a capture as event==1 in the current cycle with the registered event==0 from the previous cycle.
REQ-014 On a capture it shall push the count value present in that same cycle; the value shall appear in the FIFO at the next clock edge.
REQ-015 Pop shall occur when cap_valid && cap_ready at a clock edge; the pop shall advance the read pointer and decrement level.
REQ-016 The FIFO shall be first-word-fall-through: cap_data is valid in the cycle after the push into an empty FIFO, with no extra read latency.
REQ-017 cap_valid shall equal (level != 0); cap_data is don't-care while cap_valid==0 but shall not change while cap_valid==1 && cap_ready==0.
REQ-018 Push and pop in the same cycle: both shall take effect, and level shall be unchanged.
REQ-019 Full (level==DEPTH) with push and pop in the same cycle: both shall be accepted, with no overflow.
REQ-020 Full with push and no pop: the new sample shall be dropped, FIFO contents shall be unchanged, and overflow shall be set at the next edge.
REQ-021 clear_ovf==1 shall clear overflow at the next edge.
REQ-022 If clear_ovf==1 and a drop occur in the same cycle, overflow shall be 1 after the edge (set wins).
REQ-023 Pointers shall be log2(DEPTH) bits and wrap modulo DEPTH; level shall never exceed DEPTH or go below 0.
REQ-024 Pop with cap_ready==1 while empty shall be ignored.

Reset
REQ-025 While reset==1 at an edge, the block shall set read and write pointers to 0, level to 0, cap_valid to 0, overflow to 0, and all storage entries to 0.
REQ-026 The registered event shall reset to 1, so that an event held high through reset produces no capture.
REQ-027 Reset shall override any push, pop or clear in the same cycle; reset mid-stream shall discard all buffered samples.

Structure
REQ-028 A shared package count_capture_pkg shall hold WIDTH and DEPTH defaults, the derived PTR_W and LVL_W constants, and a count_t typedef.
REQ-029 Storage, pointers and level shall live in one sub-module, sync_fifo (parameterised WIDTH/DEPTH, FWFT, synchronous reset).
REQ-030 Edge detection and overflow logic shall live in count_capture_fifo.

Verification
REQ-031 Reset, then event pulse while count=8'h2A, cap_ready=0 -> next cycle cap_valid=1, cap_data=8'h2A, level=1.
REQ-032 Four captures at count=3,7,11,15, cap_ready=0 -> level=4; then cap_ready=1 -> cap_data sequence 3,7,11,15, cap_valid=0 after the fourth pop.
REQ-033 FIFO full, fifth capture at count=20 with cap_ready=0 -> overflow=1, level=4, and a later drain yields no 20.
REQ-034 FIFO full, capture at count=30 with cap_ready=1 in the same cycle -> overflow=0, level=4, and 30 is the last sample drained.
REQ-035 overflow=1, clear_ovf=1 coinciding with a drop -> overflow stays 1; clear_ovf=1 alone next cycle -> overflow=0.
REQ-036 event held high across reset deassertion with level=2 before reset -> level=0, cap_valid=0, and no capture until event falls and rises again.
